// File: rtl/inst_fetch_sequencer.sv
// Instruction fetch sequencer: issues four byte reads per instruction, assembles
// big-endian 32-bit words and queues {inst, pc} in a small prefetch FIFO.
module inst_fetch_sequencer #(
  parameter int                     ADDR_LEN   = 32,
  parameter int                     WORD_LEN   = 8,
  parameter int                     INST_LEN   = 32,
  parameter int                     MEM_SIZE   = 2048,
  parameter int                     FIFO_DEPTH = 2,
  parameter logic [ADDR_LEN-1:0]    RESET_PC   = '0,
  parameter logic [INST_LEN-1:0]    NOP_INST   = 32'hE0000000
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic                mem_rd_en,
  input  logic [WORD_LEN-1:0] mem_data,
  output logic [INST_LEN-1:0] inst,
  output logic [ADDR_LEN-1:0] inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  input  logic                branch_taken,
  input  logic [ADDR_LEN-1:0] branch_addr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_LEN:0]    MEM_LIMIT = (ADDR_LEN + 1)'(MEM_SIZE);
  localparam logic [CNT_W:0]       DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  // Issue side
  logic [ADDR_LEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]          issue_k_q, issue_k_d;
  // Capture side
  logic                asm_busy_q, asm_busy_d;
  logic [ADDR_LEN-1:0] asm_pc_q, asm_pc_d;
  logic [1:0]          cap_k_q, cap_k_d;
  logic [INST_LEN-1:0] shift_q, shift_d;
  logic                rd_pend_q, rd_pend_d;
  // Prefetch FIFO
  logic [INST_LEN-1:0] inst_mem_q [FIFO_DEPTH];
  logic [ADDR_LEN-1:0] pc_mem_q   [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                issue_rd;
  logic [ADDR_LEN-1:0] issue_addr;
  logic                out_of_range;
  logic                space_ok;
  logic                push;
  logic                push_fire;
  logic [INST_LEN-1:0] push_inst;
  logic [ADDR_LEN-1:0] push_pc;
  logic                pop;
  logic                unused_branch_lsbs;

  assign unused_branch_lsbs = ^branch_addr[1:0];

  assign out_of_range = {1'b0, fetch_pc_q} >= MEM_LIMIT;
  // An in-flight instruction already owns a FIFO slot.
  assign space_ok     = ({1'b0, count_q} + (CNT_W + 1)'(asm_busy_q)) < DEPTH_EXT;
  assign pop          = (count_q != '0) && inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    issue_k_d  = issue_k_q;
    asm_busy_d = asm_busy_q;
    asm_pc_d   = asm_pc_q;
    cap_k_d    = cap_k_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    issue_rd   = 1'b0;
    issue_addr = fetch_pc_q + ADDR_LEN'(issue_k_q);
    push       = 1'b0;
    push_inst  = '0;
    push_pc    = '0;
    push_fire  = 1'b0;

    // Capture the byte read in the previous cycle; the fourth one completes the word.
    if (rd_pend_q) begin
      shift_d = {shift_q[INST_LEN-WORD_LEN-1:0], mem_data};
      cap_k_d = cap_k_q + 2'd1;
      if (cap_k_q == 2'd3) begin
        push       = 1'b1;
        push_inst  = shift_d;
        push_pc    = asm_pc_q;
        asm_busy_d = 1'b0;
      end
    end

    if (issue_k_q != 2'd0) begin
      issue_rd  = 1'b1;
      issue_k_d = issue_k_q + 2'd1;
      if (issue_k_q == 2'd3) begin
        fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
      end
    end else if (space_ok) begin
      if (out_of_range) begin
        // Wait for the capture side to drain so two pushes never collide.
        if (!asm_busy_q) begin
          push       = 1'b1;
          push_inst  = NOP_INST;
          push_pc    = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_LEN'(4);
        end
      end else begin
        issue_rd   = 1'b1;
        issue_k_d  = 2'd1;
        asm_busy_d = 1'b1;
        asm_pc_d   = fetch_pc_q;
      end
    end

    rd_pend_d = issue_rd;
    push_fire = push;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Redirect wins over everything but reset; the stale byte in flight is dropped via rd_pend.
    if (branch_taken) begin
      fetch_pc_d = {branch_addr[ADDR_LEN-1:2], 2'b00};
      issue_k_d  = 2'd0;
      asm_busy_d = 1'b0;
      cap_k_d    = 2'd0;
      shift_d    = '0;
      rd_pend_d  = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      push_fire  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      issue_k_q  <= 2'd0;
      asm_busy_q <= 1'b0;
      asm_pc_q   <= '0;
      cap_k_q    <= 2'd0;
      shift_q    <= '0;
      rd_pend_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      issue_k_q  <= issue_k_d;
      asm_busy_q <= asm_busy_d;
      asm_pc_q   <= asm_pc_d;
      cap_k_q    <= cap_k_d;
      shift_q    <= shift_d;
      rd_pend_q  <= rd_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push_fire) begin
      inst_mem_q[wr_ptr_q] <= push_inst;
      pc_mem_q[wr_ptr_q]   <= push_pc;
    end
  end

  // Read strobe and address are gated by reset so they drop the moment reset asserts.
  assign mem_rd_en  = rst & issue_rd;
  assign mem_addr   = rst ? issue_addr : '0;
  assign inst       = inst_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
  assign inst_valid = (count_q != '0);

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Directed bench for inst_fetch_sequencer: byte memory model, pop scoreboard,
// cycle-accurate spot checks of latency, freeze, redirect, out-of-range and reset.
module tb_inst_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_data;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        branch_taken;
  logic [31:0] branch_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int oob_cnt = 0;

  logic [7:0]  mem [0:2047];
  logic [63:0] exp_q[$];

  inst_fetch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_rd_en    (mem_rd_en),
    .mem_data     (mem_data),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr)
  );

  // Clock and reset defaults
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte memory: data for the address sampled at an edge is on mem_data the next cycle.
  initial mem_data = 8'h00;
  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (mem_addr < 32'd2048) begin
        mem_data <= mem[mem_addr[10:0]];
      end else begin
        oob_cnt++;
        mem_data <= 8'h00;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    mem[addr]     = w[31:24];
    mem[addr + 1] = w[23:16];
    mem[addr + 2] = w[15:8];
    mem[addr + 3] = w[7:0];
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted head must match the next expected {inst, pc}.
  always @(posedge clk) begin
    if (rst && inst_valid && inst_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {32'h0, inst_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("pop_order", {inst, inst_pc}, exp_q.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = i[7:0];
    put_word(32'h000, 32'hE3A00014);
    put_word(32'h004, 32'hE3A01A01);
    put_word(32'h008, 32'h99AABBCC);
    put_word(32'h090, 32'h11223344);
    put_word(32'h094, 32'h55667788);
    put_word(32'h7FC, 32'hA1B2C3D4);

    rst          = 1'b0;
    inst_ready   = 1'b1;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;

    // ---- Run 1: sequential fetch, branch mid-assembly, branch with handshake, out-of-range
    exp_q.push_back({32'hE3A00014, 32'h000});
    exp_q.push_back({32'hE3A01A01, 32'h004});
    exp_q.push_back({32'h11223344, 32'h090});
    exp_q.push_back({32'hA1B2C3D4, 32'h7FC});

    step(3);
    check("rst_valid", {63'h0, inst_valid}, 64'h0);
    check("rst_rd_en", {63'h0, mem_rd_en}, 64'h0);
    check("rst_addr", {32'h0, mem_addr}, 64'h0);
    check("rst_inst", {32'h0, inst}, 64'h0);
    check("rst_pc", {32'h0, inst_pc}, 64'h0);

    rst = 1'b1;
    #1;  // cycle 0
    check("c0_rd_en", {63'h0, mem_rd_en}, 64'h1);
    check("c0_addr", {32'h0, mem_addr}, 64'h0);
    step(1);  // edge 1
    check("e1_addr", {32'h0, mem_addr}, 64'h1);
    step(3);  // edge 4
    check("e4_addr", {32'h0, mem_addr}, 64'h4);
    check("e4_valid", {63'h0, inst_valid}, 64'h0);
    step(1);  // edge 5
    check("e5_valid", {63'h0, inst_valid}, 64'h1);
    check("e5_head", {inst, inst_pc}, {32'hE3A00014, 32'h0});
    step(1);  // edge 6
    check("e6_valid", {63'h0, inst_valid}, 64'h0);
    step(3);  // edge 9
    check("e9_head", {31'h0, inst_valid, inst}, {31'h0, 1'b1, 32'hE3A01A01});
    check("e9_pc", {32'h0, inst_pc}, 64'h4);
    step(2);  // edge 11: byte 2 of pc 8 is on mem_data
    branch_taken = 1'b1;
    branch_addr  = 32'h92;
    step(1);  // edge 12: redirect taken
    branch_taken = 1'b0;
    check("br_rd_en", {63'h0, mem_rd_en}, 64'h1);
    check("br_addr", {32'h0, mem_addr}, 64'h90);
    check("br_valid", {63'h0, inst_valid}, 64'h0);
    step(4);  // edge 16
    check("br_valid_e16", {63'h0, inst_valid}, 64'h0);
    step(1);  // edge 17
    check("br_head", {31'h0, inst_valid, inst}, {31'h0, 1'b1, 32'h11223344});
    check("br_pc", {32'h0, inst_pc}, 64'h90);
    branch_taken = 1'b1;  // coincides with a handshake at edge 18
    branch_addr  = 32'h7FC;
    step(1);  // edge 18
    branch_taken = 1'b0;
    check("bh_valid", {63'h0, inst_valid}, 64'h0);
    check("bh_addr", {31'h0, mem_rd_en, mem_addr}, {31'h0, 1'b1, 32'h7FC});
    step(3);  // edge 21
    check("oor_last_read", {31'h0, mem_rd_en, mem_addr}, {31'h0, 1'b1, 32'h7FF});
    step(1);  // edge 22
    check("oor_no_read", {63'h0, mem_rd_en}, 64'h0);
    step(1);  // edge 23
    check("oor_7fc", {31'h0, inst_valid, inst}, {31'h0, 1'b1, 32'hA1B2C3D4});
    step(1);  // edge 24
    check("oor_nop", {inst, inst_pc}, {32'hE0000000, 32'h800});
    inst_ready = 1'b0;
    step(2);  // edge 26
    check("oor_hold", {inst, inst_pc}, {32'hE0000000, 32'h800});
    check("oor_rd_en", {63'h0, mem_rd_en}, 64'h0);
    check("run1_pops_left", 64'(exp_q.size()), 64'h0);

    // ---- Run 2: async reset from a full FIFO, then freeze
    rst = 1'b0;
    #1;
    check("arst_valid", {63'h0, inst_valid}, 64'h0);
    check("arst_rd_en", {63'h0, mem_rd_en}, 64'h0);
    exp_q.push_back({32'hE3A00014, 32'h000});
    exp_q.push_back({32'hE3A01A01, 32'h004});
    step(2);
    rst = 1'b1;
    inst_ready = 1'b1;
    #1;  // cycle 0
    step(2);  // edge 2
    inst_ready = 1'b0;
    step(7);  // edge 9
    check("frz_head", {31'h0, inst_valid, inst}, {31'h0, 1'b1, 32'hE3A00014});
    check("frz_rd_en", {63'h0, mem_rd_en}, 64'h0);
    step(3);  // edge 12
    check("frz_hold", {inst, inst_pc}, {32'hE3A00014, 32'h0});
    check("frz_rd_en2", {63'h0, mem_rd_en}, 64'h0);
    inst_ready = 1'b1;
    step(1);  // edge 13
    check("frz_resume", {31'h0, mem_rd_en, mem_addr}, {31'h0, 1'b1, 32'h8});
    check("frz_head2", {inst, inst_pc}, {32'hE3A01A01, 32'h4});
    step(1);  // edge 14
    check("frz_empty", {63'h0, inst_valid}, 64'h0);
    step(4);  // edge 18
    check("frz_pc8", {31'h0, inst_valid, inst}, {31'h0, 1'b1, 32'h99AABBCC});
    inst_ready = 1'b0;
    step(2);  // edge 20: pc 0xC mid-assembly
    check("pre_arst_rd_en", {63'h0, mem_rd_en}, 64'h1);
    #2;
    rst = 1'b0;
    #1;
    check("arst2_valid", {63'h0, inst_valid}, 64'h0);
    check("arst2_rd_en", {63'h0, mem_rd_en}, 64'h0);
    check("run2_pops_left", 64'(exp_q.size()), 64'h0);

    // ---- Run 3: restart at RESET_PC with no leftovers from before reset
    exp_q.push_back({32'hE3A00014, 32'h000});
    step(2);
    rst = 1'b1;
    inst_ready = 1'b1;
    #1;  // cycle 0
    check("rs_addr", {31'h0, mem_rd_en, mem_addr}, {31'h0, 1'b1, 32'h0});
    step(2);  // edge 2
    check("rs_valid_e2", {63'h0, inst_valid}, 64'h0);
    step(2);  // edge 4
    check("rs_valid_e4", {63'h0, inst_valid}, 64'h0);
    step(1);  // edge 5
    check("rs_head", {31'h0, inst_valid, inst}, {31'h0, 1'b1, 32'hE3A00014});
    step(1);  // edge 6
    inst_ready = 1'b0;
    step(2);
    check("run3_pops_left", 64'(exp_q.size()), 64'h0);
    check("oob_reads", 64'(oob_cnt), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_sequencer.md
Name: inst_fetch_sequencer

Overview:
- Sequences the byte-wide instruction memory (8-bit words, byte-addressed) and assembles each 32-bit instruction from 4 consecutive byte reads. Byte order is big-endian: the byte at address A is bits [31:24], A+1 is [23:16], A+2 is [15:8], A+3 is [7:0].
- Owns the fetch PC and buffers assembled instructions in a small FIFO for the IF/ID stage.
- Handles pipeline freeze (through ready/valid) and branch redirect (through flush).

Parameters:
- ADDR_LEN, 32, fetch PC and memory address width
- WORD_LEN, 8, memory word (byte) width
- INST_LEN, 32, instruction width (always 4 words)
- MEM_SIZE, 2048, instruction memory size in bytes; fetches at or above this return NOP
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, ≥1)
- RESET_PC, 0, PC after reset
- NOP_INST, 32'hE0000000, instruction substituted for out-of-range fetches

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- mem_addr  out  ADDR_LEN  byte address presented to instruction memory
- mem_rd_en  out  1  read issued this cycle
- mem_data  in  WORD_LEN  byte returned one cycle after mem_rd_en
- inst  out  INST_LEN  FIFO head instruction
- inst_pc  out  ADDR_LEN  byte address of inst
- inst_valid  out  1  FIFO not empty
- inst_ready  in  1  consumer accepts; low = freeze
- branch_taken  in  1  redirect request
- branch_addr  in  ADDR_LEN  redirect target

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC, FIFO empty, byte counters=0, in-flight=0, mem_rd_en=0, mem_addr=0, inst_valid=0, inst=0, inst_pc=0.
- Issue side: a 2-bit issue counter k issues mem_addr=fetch_pc+k with mem_rd_en=1 on consecutive cycles, k=0..3.
  - A new instruction starts only if (FIFO count + instructions in flight) < FIFO_DEPTH.
  - After k=3: fetch_pc += 4, k=0.
- Capture side: a byte register is loaded from mem_data on the cycle after each read (shift left by WORD_LEN, OR in the new byte).
  - After the 4th byte is captured, {bytes, pc} is pushed into the FIFO.
- Out-of-range: if fetch_pc ≥ MEM_SIZE at instruction start, no memory read is issued. {NOP_INST, fetch_pc} is pushed in one cycle (subject to the FIFO-space rule), then fetch_pc += 4.
- Latency: from reset release with inst_ready=1, the first read is issued at edge 1 and inst_valid rises after edge 5.
- Throughput: steady state is 1 instruction per 4 cycles. Reads are back-to-back, so a new instruction's byte 0 is issued in the cycle after the previous instruction's byte 3.
- Output handshake:
  - inst/inst_pc reflect the FIFO head.
  - A pop occurs when inst_valid && inst_ready.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - While inst_ready=0, the head and all outputs hold stable. Fetching continues until the FIFO is full, then mem_rd_en=0.
- Branch (branch_taken=1 at an edge):
  - FIFO is cleared, regardless of inst_ready. A handshake completing on that same edge is still considered consumed by the downstream stage.
  - The partially assembled instruction is discarded. A byte returning on the following cycle is ignored (a drop flag is set for one cycle).
  - fetch_pc = {branch_addr[ADDR_LEN-1:2], 2'b00}, k=0.
  - The first read of the target is issued on the cycle after the branch edge. inst_valid is 0 for at least 5 cycles after it.
- Priority: reset > branch > push/pop.
- Branch while frozen: it still flushes. Back-to-back branches: the last one wins.
- fetch_pc wraps modulo 2^ADDR_LEN (no saturation).
- Reset mid-assembly: all state is dropped immediately, asynchronously. No FIFO push ever occurs from pre-reset bytes.
- Occupancy bound: FIFO count never exceeds FIFO_DEPTH; mem_rd_en is never asserted when a completed instruction would have nowhere to go.

Test Plan:
- Sequential fetch:
  - Stimulus: memory holds 0xE3A00014 at 0, 0xE3A01A01 at 4; inst_ready=1.
  - Required response: mem_addr issues 0,1,2,3,4,...; inst_valid rises after edge 5 with inst=0xE3A00014, inst_pc=0; the next instruction (0xE3A01A01, pc 4) follows 4 cycles later.
- Freeze:
  - Stimulus: inst_ready=0 from cycle 3.
  - Required response: FIFO fills to 2 entries (pcs 0, 4); mem_rd_en=0 afterwards; inst=0xE3A00014 held stable. After inst_ready=1, pops occur in order and fetching resumes at pc 8.
- Branch mid-assembly:
  - Stimulus: branch_taken=1 with branch_addr=0x92 while byte 2 of pc 8 is in flight.
  - Required response: FIFO empties; next mem_addr=0x90; the first inst_valid has inst_pc=0x90; no instruction from pc 8 ever appears.
- Branch with handshake:
  - Stimulus: branch_taken=1 coincides with inst_valid && inst_ready.
  - Required response: the head is consumed, the FIFO is empty afterwards, and no duplicate is produced.
- Out-of-range:
  - Stimulus: branch to 0x7FC with MEM_SIZE=2048.
  - Required response: pc 0x7FC is read from memory; pc 0x800 yields inst=0xE0000000 with no mem_rd_en.
- Async reset:
  - Stimulus: rst=0 mid-assembly, between clock edges.
  - Required response: inst_valid=0 and mem_rd_en=0 immediately; after release, fetching restarts at RESET_PC.
